// File: rtl/demux4_sched.sv
// 1-to-4 demux sequencer: one holding register feeds four lanes, addressed or round-robin.
// Optional macro DEMUX4_SCHED_CNT_EN adds per-lane 8-bit delivery counters on lane_cnt.
module demux4_sched #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_mode,
  output logic              in_ready,
  input  logic [3:0]        lane_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic              drop,
  output logic [31:0]       lane_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          hold_lane_q, hold_lane_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                drop_q, drop_d;

  logic                fire_out_s;
  logic                fire_in_s;
  logic [1:0]          sel_lane_s;
  logic                lane_ok_s;
  logic [2:0]          rr_pick_s;

  // First enabled lane at or after ptr (mod 4); result is {found, lane}.
  function automatic logic [2:0] rr_pick(input logic [3:0] en, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (en[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign fire_out_s = (state_q == FULL) && out_ready[hold_lane_q];
  assign in_ready   = (state_q == EMPTY) || fire_out_s;
  assign fire_in_s  = in_valid && in_ready;
  assign rr_pick_s  = rr_pick(lane_en, rr_ptr_q);

  assign out_valid = (state_q == FULL) ? (4'b0001 << hold_lane_q) : 4'b0000;
  assign out_data  = hold_data_q;
  assign drop      = drop_q;

  // Lane selection for the word currently offered by the producer.
  always_comb begin
    sel_lane_s = in_dest;
    lane_ok_s  = lane_en[in_dest];
    if (in_mode) begin
      sel_lane_s = rr_pick_s[1:0];
      lane_ok_s  = rr_pick_s[2];
    end else begin
      sel_lane_s = in_dest;
      lane_ok_s  = lane_en[in_dest];
    end
  end

  // Next-state logic for the holding stage and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    hold_lane_d = hold_lane_q;
    hold_data_d = hold_data_q;
    rr_ptr_d    = rr_ptr_q;
    drop_d      = 1'b0;
    if (fire_in_s && !lane_ok_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = 1'b0;
    end
    if (fire_in_s && lane_ok_s && in_mode) begin
      rr_ptr_d = sel_lane_s + 2'd1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      EMPTY: begin
        if (fire_in_s && lane_ok_s) begin
          state_d     = FULL;
          hold_lane_d = sel_lane_s;
          hold_data_d = in_data;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // A discarded word arriving on the delivering edge still empties the stage.
        if (fire_in_s && lane_ok_s) begin
          state_d     = FULL;
          hold_lane_d = sel_lane_s;
          hold_data_d = in_data;
        end else if (fire_out_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Holding stage, pointer and drop pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hold_lane_q <= 2'd0;
      hold_data_q <= '0;
      rr_ptr_q    <= 2'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_lane_q <= hold_lane_d;
      hold_data_q <= hold_data_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_q      <= drop_d;
    end
  end

`ifdef DEMUX4_SCHED_CNT_EN
  logic [7:0] cnt_q [4];

  // Per-lane delivery counters, wrapping at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= 8'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fire_out_s && (hold_lane_q == 2'(k))) cnt_q[k] <= cnt_q[k] + 8'd1;
        else cnt_q[k] <= cnt_q[k];
      end
    end
  end

  assign lane_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign lane_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_demux4_sched.sv
// Self-checking bench for demux4_sched: vector table plus scoreboard of expected deliveries.
module tb_demux4_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_mode;
  logic        in_ready;
  logic [3:0]  lane_en;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_ready;
  logic        drop;
  logic [31:0] lane_cnt;

  demux4_sched #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_mode(in_mode), .in_ready(in_ready), .lane_en(lane_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drop(drop), .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dest;
    logic       mode;
    logic [3:0] en;
    logic [1:0] exp_lane;
    logic       exp_drop;
  } vec_t;

  typedef struct {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  vec_t  vecs [19];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;
  logic  pend_drop = 1'b0;
  logic [7:0] cnt_model [4];
  int    waits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef DEMUX4_SCHED_CNT_EN
    return {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]};
`else
    return 32'd0;
`endif
  endfunction

  // Offer one word; returns number of negedges waited for in_ready (0 = timeout).
  task automatic send(input vec_t v, output int nw);
    exp_t e;
    in_valid = 1'b1; in_data = v.data; in_dest = v.dest; in_mode = v.mode; lane_en = v.en;
    nw = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (in_ready) begin nw = i; break; end
    end
    if (nw == 0) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      pend_drop = v.exp_drop;
      if (!v.exp_drop) begin
        e.lane = v.exp_lane; e.data = v.data;
        sb.push_back(e);
      end
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    check("drain_empty", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: deliveries against scoreboard, drop pulse, counter model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        check("drop", {31'd0, drop}, {31'd0, pend_drop});
        pend_drop = 1'b0;
        check("lane_cnt", lane_cnt, exp_cnt());
        if (out_valid != 4'b0000) begin
          check("onehot", 32'($onehot(out_valid)), 32'd1);
          if ((out_valid & out_ready) != 4'b0000) begin
            if (sb.size() == 0) begin
              check("unexpected_out", {28'd0, out_valid}, 32'd0);
            end else begin
              e = sb.pop_front();
              check("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << e.lane});
              check("out_data", {24'd0, out_data}, {24'd0, e.data});
              cnt_model[e.lane] = cnt_model[e.lane] + 8'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    vec_t v;
    for (int k = 0; k < 4; k++) cnt_model[k] = 8'd0;
    vecs[0]  = '{8'hA5, 2'd2, 1'b0, 4'hF, 2'd2, 1'b0};
    vecs[1]  = '{8'h3C, 2'd0, 1'b0, 4'hF, 2'd0, 1'b0};
    vecs[2]  = '{8'h10, 2'd0, 1'b1, 4'hF, 2'd0, 1'b0};
    vecs[3]  = '{8'h11, 2'd0, 1'b1, 4'hF, 2'd1, 1'b0};
    vecs[4]  = '{8'h12, 2'd0, 1'b1, 4'hF, 2'd2, 1'b0};
    vecs[5]  = '{8'h13, 2'd0, 1'b1, 4'hF, 2'd3, 1'b0};
    vecs[6]  = '{8'h14, 2'd0, 1'b1, 4'hF, 2'd0, 1'b0};
    vecs[7]  = '{8'h15, 2'd0, 1'b1, 4'hF, 2'd1, 1'b0};
    vecs[8]  = '{8'h20, 2'd0, 1'b1, 4'hF, 2'd2, 1'b0};
    vecs[9]  = '{8'h21, 2'd0, 1'b1, 4'hF, 2'd3, 1'b0};
    vecs[10] = '{8'h30, 2'd0, 1'b1, 4'hA, 2'd1, 1'b0};
    vecs[11] = '{8'h31, 2'd0, 1'b1, 4'hA, 2'd3, 1'b0};
    vecs[12] = '{8'h32, 2'd0, 1'b1, 4'hA, 2'd1, 1'b0};
    vecs[13] = '{8'h40, 2'd0, 1'b1, 4'h0, 2'd0, 1'b1};
    vecs[14] = '{8'h41, 2'd3, 1'b0, 4'h7, 2'd0, 1'b1};
    vecs[15] = '{8'h42, 2'd0, 1'b1, 4'hF, 2'd2, 1'b0};
    vecs[16] = '{8'h43, 2'd1, 1'b0, 4'h2, 2'd1, 1'b0};
    vecs[17] = '{8'h44, 2'd0, 1'b1, 4'h1, 2'd0, 1'b0};
    vecs[18] = '{8'h45, 2'd2, 1'b0, 4'hB, 2'd0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0; in_mode = 1'b0;
    lane_en = 4'hF; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_drop", {31'd0, drop}, 32'd0);
    check("rst_lane_cnt", lane_cnt, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Back-to-back vectors with all lanes ready: in_ready must be high each cycle.
    for (int i = 0; i < 19; i++) begin
      send(vecs[i], waits);
      check("in_ready_b2b", 32'(waits), 32'd1);
    end
    drain();

    // Hold a word on lane 3 while its consumer stalls.
    out_ready = 4'b0111;
    v = '{8'h77, 2'd3, 1'b0, 4'hF, 2'd3, 1'b0};
    send(v, waits);
    lane_en = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_out_valid", {28'd0, out_valid}, 32'h8);
      check("hold_out_data", {24'd0, out_data}, 32'h77);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 4'hF;
    v = '{8'h88, 2'd0, 1'b0, 4'hF, 2'd0, 1'b0};
    send(v, waits);
    check("release_same_edge", 32'(waits), 32'd1);
    drain();

    // Reset while FULL discards the held word.
    out_ready = 4'h0;
    v = '{8'h99, 2'd1, 1'b0, 4'hF, 2'd1, 1'b0};
    send(v, waits);
    @(negedge clk);
    check("full_before_rst", {28'd0, out_valid}, 32'h2);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    pend_drop = 1'b0;
    for (int k = 0; k < 4; k++) cnt_model[k] = 8'd0;
    @(negedge clk);
    check("midrst_out_valid", {28'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_lane_cnt", lane_cnt, 32'd0);
    @(posedge clk); #1;
    out_ready = 4'hF;
    mon_en = 1'b1;

    // 257 deliveries to lane 1 exercise the counter wrap.
    for (int i = 0; i < 257; i++) begin
      v = '{8'(i), 2'd1, 1'b0, 4'hF, 2'd1, 1'b0};
      send(v, waits);
    end
    drain();
    @(negedge clk);
`ifdef DEMUX4_SCHED_CNT_EN
    check("cnt_wrap", lane_cnt, 32'h0000_0100);
`else
    check("cnt_tied", lane_cnt, 32'h0000_0000);
`endif
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux4_sched.md
# demux4_sched

Sequencer for the 1-to-4 demultiplexer datapath: accepts a stream of data words over a valid/ready handshake and dispatches each word to exactly one of four output lanes. Lane selection is either addressed (per-word destination) or round-robin over the enabled lanes. One registered holding stage decouples the input from the lanes, giving one word per cycle throughput when the selected lane is ready. The block sits between a single producer and four lane consumers.

## Interface
- DATA_W, 8, width of data word
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has a word
- in_data  input  DATA_W  word
- in_dest  input  2  destination lane (addressed mode)
- in_mode  input  1  0 = addressed, 1 = round-robin; sampled with each word
- in_ready  output  1  block can accept a word this cycle
- lane_en  input  4  per-lane enable mask
- out_valid  output  4  one-hot; bit k = word valid for lane k
- out_data  output  DATA_W  held word, shared by all lanes
- out_ready  input  4  per-lane consumer ready
- drop  output  1  registered one-cycle pulse: accepted word was discarded
- lane_cnt  output  32  four 8-bit delivery counters, lane k in bits [8k+7:8k]

## Operation
- Internal state: hold_valid, hold_lane[1:0], hold_data, rr_ptr[1:0], drop.
- States: EMPTY (hold_valid=0) and FULL (hold_valid=1).
- fire_in = in_valid & in_ready; fire_out = hold_valid & out_ready[hold_lane].
- in_ready = !hold_valid | fire_out (combinational through out_ready).
- out_valid = hold_valid ? (4'b0001 << hold_lane) : 4'b0000; out_data = hold_data.
- Lane choice on fire_in:
  - Addressed: lane = in_dest. If lane_en[in_dest]=0, the word is accepted and discarded. rr_ptr is unchanged.
  - Round-robin: lane = first k with lane_en[k]=1, searching rr_ptr, rr_ptr+1, ... modulo 4. rr_ptr <= lane+1, wrapping 3->0. If lane_en=0000, the word is accepted and discarded and rr_ptr is unchanged.
- Transitions:
  - EMPTY, fire_in, lane enabled -> FULL; capture data and lane.
  - FULL, fire_out, no fire_in -> EMPTY.
  - FULL, fire_out, fire_in with a valid lane -> FULL; new word captured the same edge.
  - Discarded word never enters FULL. drop=1 for the cycle after the accepting edge.
- lane_en changes while FULL do not affect the held word; it is delivered to hold_lane.
- lane_cnt[k] increments by 1 on each fire_out with hold_lane=k, wrapping 255->0.

## Timing
- Reset (rst_n=0 at an edge): hold_valid=0, hold_lane=0, hold_data=0, rr_ptr=0, drop=0, lane_cnt=0. Resulting outputs: out_valid=0000, out_data=0, in_ready=1.
- Reset mid-operation discards the held word; no out_valid in the following cycle.
- Latency: word accepted at edge N appears on out_valid/out_data after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while the target lane holds out_ready=1.
- out_valid and out_data remain stable while FULL and not fire_out.
- out_ready on non-selected lanes is ignored.

## Configuration
- DEMUX4_SCHED_CNT_EN defined: lane_cnt counters implemented as described.
- DEMUX4_SCHED_CNT_EN undefined: no counter registers; lane_cnt port remains and is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then addressed words A5/dest 2 and 3C/dest 0 back-to-back with out_ready=1111 -> out_valid 0100 carrying A5, then 0001 carrying 3C, on consecutive cycles; in_ready stays 1.
- Round-robin, lane_en=1111, 6 words -> lanes 0,1,2,3,0,1 in order; rr_ptr ends at 2.
- Round-robin, lane_en=1010, 3 words -> lanes 1,3,1. Then lane_en=0000 plus 1 word -> drop pulse, no out_valid, rr_ptr unchanged.
- Hold word on lane 3 with out_ready[3]=0 for 4 cycles (other ready bits 1) -> out_valid 1000 and data stable, in_ready=0. Set out_ready[3]=1 with a new word pending -> delivery and capture on the same edge.
- Assert rst_n=0 while FULL -> next cycle out_valid=0000, in_ready=1, lane_cnt=0.
- With DEMUX4_SCHED_CNT_EN: 257 deliveries to lane 1 -> lane_cnt[15:8]=1, others 0. Without the macro -> lane_cnt=0 throughout.
